// File: rtl/dna_pkg.sv
// dna_pkg: shared types and constants for the 2-bit nucleotide stream blocks.
//   base_t    - one nucleotide, 2 bits.
//   MOTIF     - the 4-base marker. Element 0 sits in bits[1:0] so it is sent
//               first, in the same order as data words.
//   MOTIF_LEN - number of bases in the marker.
//   state_e   - transmit FSM states.
package dna_pkg;

  typedef logic [1:0] base_t;

  localparam int MOTIF_LEN = 4;

  // Send order is 00, 01, 11, 10 (bits[1:0] leave first).
  localparam logic [2*MOTIF_LEN-1:0] MOTIF = {2'b10, 2'b11, 2'b01, 2'b00};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_MOTIF = 2'd2
  } state_e;

endpackage

// File: rtl/dna_word_hold.sv
// dna_word_hold: single-entry valid/ready holding register for stream blocks.
// Ports:
//   clk, rst_n  - clock and synchronous active-low reset
//   in_data_i   - word offered by the producer
//   in_valid_i  - producer has a word
//   in_ready_o  - entry is empty and out of reset, so a word can be taken
//   out_data_o  - held word
//   out_valid_o - entry holds a word
//   out_pop_i   - consumer takes the held word this cycle
module dna_word_hold
  import dna_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] in_data_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  output logic [W-1:0] out_data_o,
  output logic         out_valid_o,
  input  logic         out_pop_i
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  // Ready is gated by reset so nothing is accepted while the block is held in reset.
  assign in_ready_o  = rst_n && !valid_q;
  assign out_data_o  = data_q;
  assign out_valid_o = valid_q;

  // A push can only happen when empty and a pop only when full, so the two
  // never collide; the push is applied last so a refill always wins.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (out_pop_i) begin
      valid_d = 1'b0;
    end
    if (in_valid_i && in_ready_o) begin
      valid_d = 1'b1;
      data_d  = in_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/dna_seq_tx.sv
// dna_seq_tx: serialises packed words of 2-bit bases onto the dna stream and
// inserts the 4-base marker between words on request.
// Ports:
//   clk, rst_n            - clock and synchronous active-low reset
//   word_in/valid/ready   - packed word input handshake, bits[1:0] sent first
//   motif_req             - single-cycle request to insert the marker
//   dna_out/valid/ready   - one base per transfer
//   motif_sent            - pulse in the cycle after the last marker base transfers
//   busy                  - shifting, or a word / marker is waiting
//   bases_sent            - wrapping count of transferred bases
module dna_seq_tx
  import dna_pkg::*;
#(
  parameter int    BPW       = 8,
  parameter base_t IDLE_BASE = 2'b10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2*BPW-1:0] word_in,
  input  logic             word_valid,
  output logic             word_ready,
  input  logic             motif_req,
  input  logic             dna_ready,
  output base_t            dna_out,
  output logic             dna_valid,
  output logic             motif_sent,
  output logic             busy,
  output logic [15:0]      bases_sent
);

  localparam int WW = 2 * BPW;
  // The shifter also carries the marker, so it is at least marker-wide.
  localparam int SW = (WW > 2 * MOTIF_LEN) ? WW : 2 * MOTIF_LEN;
  localparam int IW = ($clog2(BPW) > 2) ? $clog2(BPW) : 2;
  localparam logic [IW-1:0] LAST_DATA  = IW'(BPW - 1);
  localparam logic [IW-1:0] LAST_MOTIF = IW'(MOTIF_LEN - 1);

  state_e          state_q, state_d;
  logic [SW-1:0]   shift_q, shift_d;
  logic [IW-1:0]   idx_q, idx_d;
  base_t           dna_out_q, dna_out_d;
  logic            dna_valid_q, dna_valid_d;
  logic            pending_q, pending_d;
  logic            motif_sent_q, motif_sent_d;
  logic            busy_q, busy_d;
  logic [15:0]     bases_q, bases_d;

  logic [WW-1:0]   hold_data;
  logic            hold_valid;
  logic            hold_pop;
  logic            word_push;
  logic            hold_next;
  logic            xfer;
  logic            last_base;
  logic            boundary;

  dna_word_hold #(.W(WW)) u_hold (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data_i  (word_in),
    .in_valid_i (word_valid),
    .in_ready_o (word_ready),
    .out_data_o (hold_data),
    .out_valid_o(hold_valid),
    .out_pop_i  (hold_pop)
  );

  assign xfer      = dna_valid_q && dna_ready;
  assign last_base = xfer && (((state_q == ST_SHIFT) && (idx_q == LAST_DATA)) ||
                              ((state_q == ST_MOTIF) && (idx_q == LAST_MOTIF)));
  // Loading at the last transfer of a unit is what gives the bubble-free handoff.
  assign boundary  = (state_q == ST_IDLE) || last_base;
  assign word_push = word_valid && word_ready;
  assign hold_next = (hold_valid && !hold_pop) || word_push;

  // Next-state logic. dna_out is computed one cycle ahead so it leaves a flop.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    idx_d       = idx_q;
    dna_out_d   = dna_out_q;
    dna_valid_d = dna_valid_q;
    pending_d   = pending_q;
    hold_pop    = 1'b0;

    if (boundary) begin
      idx_d = '0;
      if (pending_q) begin
        // A request arriving in this same cycle is absorbed into this marker.
        state_d     = ST_MOTIF;
        shift_d     = SW'(MOTIF);
        dna_out_d   = MOTIF[1:0];
        dna_valid_d = 1'b1;
        pending_d   = 1'b0;
      end else begin
        if (motif_req) begin
          pending_d = 1'b1;
        end
        if (hold_valid) begin
          state_d     = ST_SHIFT;
          shift_d     = SW'(hold_data);
          dna_out_d   = hold_data[1:0];
          dna_valid_d = 1'b1;
          hold_pop    = 1'b1;
        end else begin
          state_d     = ST_IDLE;
          dna_out_d   = IDLE_BASE;
          dna_valid_d = 1'b0;
        end
      end
    end else begin
      if (motif_req) begin
        pending_d = 1'b1;
      end
      if (xfer) begin
        idx_d     = idx_q + IW'(1);
        shift_d   = shift_q >> 2;
        dna_out_d = shift_q[3:2];
      end
    end
  end

  assign motif_sent_d = (state_q == ST_MOTIF) && last_base;
  assign bases_d      = xfer ? (bases_q + 16'd1) : bases_q;
  assign busy_d       = (state_d != ST_IDLE) || hold_next || pending_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      shift_q      <= '0;
      idx_q        <= '0;
      dna_out_q    <= IDLE_BASE;
      dna_valid_q  <= 1'b0;
      pending_q    <= 1'b0;
      motif_sent_q <= 1'b0;
      busy_q       <= 1'b0;
      bases_q      <= 16'd0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      idx_q        <= idx_d;
      dna_out_q    <= dna_out_d;
      dna_valid_q  <= dna_valid_d;
      pending_q    <= pending_d;
      motif_sent_q <= motif_sent_d;
      busy_q       <= busy_d;
      bases_q      <= bases_d;
    end
  end

  assign dna_out    = dna_out_q;
  assign dna_valid  = dna_valid_q;
  assign motif_sent = motif_sent_q;
  assign busy       = busy_q;
  assign bases_sent = bases_q;

endmodule

// File: tb/tb_dna_seq_tx.sv
// tb_dna_seq_tx: scoreboard bench for dna_seq_tx with BPW=4.
// Expected bases are queued when a word is accepted or a marker is requested;
// the monitor pops one per observed base transfer.
module tb_dna_seq_tx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  word_in = 8'h00;
  logic        word_valid = 1'b0;
  logic        word_ready;
  logic        motif_req = 1'b0;
  logic        dna_ready = 1'b1;
  logic [1:0]  dna_out;
  logic        dna_valid;
  logic        motif_sent;
  logic        busy;
  logic [15:0] bases_sent;

  int          checks = 0;
  int          errors = 0;
  logic [1:0]  sb[$];
  logic [15:0] xferCount = 16'd0;
  int          motifSentCount = 0;
  int          cyc = 0;
  int          firstXferCyc = 0;
  int          lastXferCyc = 0;
  bit          markArmed = 1'b0;
  bit          randReady = 1'b0;

  dna_seq_tx #(.BPW(4), .IDLE_BASE(2'b10)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .word_in   (word_in),
    .word_valid(word_valid),
    .word_ready(word_ready),
    .motif_req (motif_req),
    .dna_ready (dna_ready),
    .dna_out   (dna_out),
    .dna_valid (dna_valid),
    .motif_sent(motif_sent),
    .busy      (busy),
    .bases_sent(bases_sent)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Random downstream back-pressure, only while enabled.
  always @(posedge clk) begin
    if (randReady) begin
      #1;
      dna_ready = ($urandom_range(0, 3) != 0);
    end
  end

  function automatic void checkOutput(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endfunction

  // Monitor: compares every transferred base with the scoreboard and tracks
  // the expected base count independently of the DUT.
  always @(negedge clk) begin
    if (!rst_n) begin
      xferCount = 16'd0;
    end else begin
      checkOutput("bases_sent", int'(bases_sent), int'(xferCount));
      if (motif_sent) motifSentCount++;
      if (dna_valid && dna_ready) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_base", 1, 0);
        end else begin
          checkOutput("dna_out", int'(dna_out), int'(sb.pop_front()));
        end
        xferCount = xferCount + 16'd1;
        lastXferCyc = cyc;
        if (markArmed) begin
          firstXferCyc = cyc;
          markArmed = 1'b0;
        end
      end else if (!dna_valid) begin
        checkOutput("idle_base", int'(dna_out), 2);
      end
    end
  end

  // Offers one word and queues its bases in send order once it is accepted.
  task automatic applyStimulus(input logic [7:0] w);
    bit ok = 1'b0;
    word_in = w;
    word_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (word_ready) begin
        for (int b = 0; b < 4; b++) sb.push_back(w[2*b +: 2]);
        ok = 1'b1;
        @(posedge clk);
        #1;
        break;
      end
    end
    word_valid = 1'b0;
    if (!ok) checkOutput("word_accept_timeout", 0, 1);
  endtask

  // Single-cycle request; queues the marker when the bench expects a new one.
  task automatic pulseMotif(input bit expectNew);
    motif_req = 1'b1;
    if (expectNew) begin
      sb.push_back(2'b00);
      sb.push_back(2'b01);
      sb.push_back(2'b11);
      sb.push_back(2'b10);
    end
    @(posedge clk);
    #1;
    motif_req = 1'b0;
  endtask

  task automatic waitDrain();
    bit ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !dna_valid && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    checkOutput("drain", int'(ok), 1);
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    word_valid = 1'b0;
    motif_req = 1'b0;
    dna_ready = 1'b1;
    #1;
    checkOutput("ready_in_reset", int'(word_ready), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sb.delete();
    checkOutput("rst_valid", int'(dna_valid), 0);
    checkOutput("rst_out", int'(dna_out), 2);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_bases", int'(bases_sent), 0);
    checkOutput("rst_msent", int'(motif_sent), 0);
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int m0;
    logic [7:0] w;

    // 1: single word, latency and order
    doReset();
    applyStimulus(8'hB4);
    checkOutput("latency_pre", int'(dna_valid), 0);
    @(posedge clk);
    #1;
    checkOutput("latency_valid", int'(dna_valid), 1);
    checkOutput("latency_base0", int'(dna_out), 0);
    m0 = motifSentCount;
    waitDrain();
    checkOutput("t1_bases", int'(bases_sent), 4);
    checkOutput("t1_no_motif", motifSentCount - m0, 0);

    // 2: back-to-back words stream with no gap
    doReset();
    markArmed = 1'b1;
    applyStimulus(8'h1B);
    applyStimulus(8'hE4);
    checkOutput("t2_hold_full", int'(word_ready), 0);
    waitDrain();
    checkOutput("t2_no_gap", lastXferCyc - firstXferCyc, 7);
    checkOutput("t2_bases", int'(bases_sent), 8);

    // 3: two requests during a word give one marker before the next word
    doReset();
    m0 = motifSentCount;
    applyStimulus(8'h6C);
    @(posedge clk); #1;
    @(posedge clk); #1;
    pulseMotif(1'b1);
    @(posedge clk); #1;
    pulseMotif(1'b0);
    applyStimulus(8'h93);
    waitDrain();
    checkOutput("t3_motif_once", motifSentCount - m0, 1);
    checkOutput("t3_bases", int'(bases_sent), 12);

    // 4: stall mid-word holds the output
    doReset();
    w = 8'h2D;
    applyStimulus(w);
    @(posedge clk); #1;
    @(posedge clk); #1;
    dna_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      checkOutput("t4_stall_valid", int'(dna_valid), 1);
      checkOutput("t4_stall_out", int'(dna_out), int'(w[3:2]));
      checkOutput("t4_stall_bases", int'(bases_sent), 1);
    end
    dna_ready = 1'b1;
    waitDrain();
    checkOutput("t4_bases", int'(bases_sent), 4);

    // 5: reset mid-word drops the word
    doReset();
    applyStimulus(8'h5A);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checkOutput("t5_ready_in_reset", int'(word_ready), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    sb.delete();
    checkOutput("t5_valid", int'(dna_valid), 0);
    checkOutput("t5_out", int'(dna_out), 2);
    checkOutput("t5_bases", int'(bases_sent), 0);
    checkOutput("t5_busy", int'(busy), 0);
    applyStimulus(8'hC3);
    waitDrain();
    checkOutput("t5_after_bases", int'(bases_sent), 4);

    // Random words and idle-time markers under random back-pressure
    doReset();
    m0 = motifSentCount;
    randReady = 1'b1;
    begin
      int nMotif = 0;
      for (int it = 0; it < 80; it++) begin
        if ($urandom_range(0, 7) == 0) begin
          waitDrain();
          pulseMotif(1'b1);
          checkOutput("rand_busy_pending", int'(busy), 1);
          nMotif++;
        end else begin
          applyStimulus(8'($urandom));
        end
      end
      waitDrain();
      randReady = 1'b0;
      @(posedge clk); #2;
      dna_ready = 1'b1;
      checkOutput("rand_motifs", motifSentCount - m0, nMotif);
    end

    // 6: counter wraps after 65536 transfers
    doReset();
    for (int k = 0; k < 16384; k++) applyStimulus(8'($urandom));
    waitDrain();
    checkOutput("t6_wrap", int'(bases_sent), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
